// File: rtl/data_gen_burst_if.sv
// Valid/ready stream carrying pattern words with burst framing flags.
// The generator drives through master; a sink or bench attaches through slave.
interface data_gen_burst_if #(
  parameter int DATA_W = 8
);
  logic              data_valid;
  logic              data_ready;
  logic [DATA_W-1:0] data_out;
  logic              sof;
  logic              eof;

  modport master (
    output data_valid,
    output data_out,
    output sof,
    output eof,
    input  data_ready
  );

  modport slave (
    input  data_valid,
    input  data_out,
    input  sof,
    input  eof,
    output data_ready
  );
endinterface

// File: rtl/data_gen_burst.sv
// Burst-framed test pattern source (INC/DEC/LFSR/WALK1) with valid/ready output,
// start/stop control and a saturating completed-burst counter.
module data_gen_burst #(
  parameter int                DATA_W     = 8,
  parameter longint            NUM_MAX    = 200,
  parameter int                BURST_LEN  = 16,
  parameter int                GAP_LEN    = 4,
  parameter int                NUM_BURSTS = 0,
  parameter logic [DATA_W-1:0] LFSR_SEED  = DATA_W'(1),
  parameter logic [DATA_W-1:0] LFSR_TAPS  = DATA_W'('hB8)
) (
  input  logic                    clk_50m,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              mode,
  data_gen_burst_if.master        bus,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             burst_cnt
);

  localparam int WC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int GC_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [WC_W-1:0]   WC_LAST     = WC_W'(BURST_LEN - 1);
  localparam logic [GC_W-1:0]   GC_LAST     = GC_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [DATA_W-1:0] DATA_MAX    = DATA_W'(NUM_MAX - 1);
  localparam logic [15:0]       BURST_LIMIT = 16'(NUM_BURSTS);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP} state_t;
  typedef enum logic [1:0] {PAT_INC, PAT_DEC, PAT_LFSR, PAT_WALK1} pattern_t;

  state_t            state_q, state_d;
  pattern_t          mode_q, mode_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [GC_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [15:0]       burst_cnt_q, burst_cnt_d;
  logic              stop_pend_q, stop_pend_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              xfer;
  logic              go_idle;
  logic [15:0]       burst_inc;

  function automatic logic [DATA_W-1:0] seed_word(input pattern_t p);
    logic [DATA_W-1:0] r;
    r = '0;
    case (p)
      PAT_INC:   r = '0;
      PAT_DEC:   r = DATA_MAX;
      PAT_LFSR:  r = LFSR_SEED;
      PAT_WALK1: r = DATA_W'(1);
    endcase
    return r;
  endfunction

  // Galois LFSR: the bit shifted out of the LSB decides whether the taps are applied.
  function automatic logic [DATA_W-1:0] next_word(input pattern_t p, input logic [DATA_W-1:0] cur);
    logic [DATA_W-1:0] r;
    r = cur;
    case (p)
      PAT_INC:   r = (cur == DATA_MAX) ? '0 : cur + DATA_W'(1);
      PAT_DEC:   r = (cur == '0) ? DATA_MAX : cur - DATA_W'(1);
      PAT_LFSR:  r = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
      PAT_WALK1: r = {cur[DATA_W-2:0], cur[DATA_W-1]};
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    data_d      = data_q;
    word_cnt_d  = word_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    burst_cnt_d = burst_cnt_q;
    stop_pend_d = stop_pend_q;
    valid_d     = valid_q;
    sof_d       = sof_q;
    eof_d       = eof_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    go_idle     = 1'b0;
    xfer        = valid_q && bus.data_ready;
    burst_inc   = (burst_cnt_q == 16'hFFFF) ? burst_cnt_q : burst_cnt_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d      = pattern_t'(mode);
          data_d      = seed_word(pattern_t'(mode));
          word_cnt_d  = '0;
          gap_cnt_d   = '0;
          burst_cnt_d = '0;
          stop_pend_d = stop;
          state_d     = ST_RUN;
          valid_d     = 1'b1;
          sof_d       = 1'b1;
          eof_d       = (WC_LAST == '0);
          busy_d      = 1'b1;
        end
      end

      ST_RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (xfer) begin
          data_d = next_word(mode_q, data_q);
          if (eof_q) begin
            burst_cnt_d = burst_inc;
            word_cnt_d  = '0;
            if (stop_pend_q || stop || (NUM_BURSTS != 0 && burst_inc == BURST_LIMIT)) begin
              go_idle = 1'b1;
            end else if (GAP_LEN == 0) begin
              sof_d = 1'b1;
              eof_d = (WC_LAST == '0);
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = '0;
              valid_d   = 1'b0;
              sof_d     = 1'b0;
              eof_d     = 1'b0;
            end
          end else begin
            word_cnt_d = word_cnt_q + WC_W'(1);
            sof_d      = 1'b0;
            eof_d      = ((word_cnt_q + WC_W'(1)) == WC_LAST);
          end
        end
      end

      ST_GAP: begin
        if (stop) stop_pend_d = 1'b1;
        // A stop seen during the gap ends the run exactly where the next burst would begin.
        if (gap_cnt_q == GC_LAST) begin
          if (stop_pend_q || stop) begin
            go_idle = 1'b1;
          end else begin
            state_d = ST_RUN;
            valid_d = 1'b1;
            sof_d   = 1'b1;
            eof_d   = (WC_LAST == '0);
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GC_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (go_idle) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= PAT_INC;
      data_q      <= '0;
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      burst_cnt_q <= '0;
      stop_pend_q <= 1'b0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      word_cnt_q  <= word_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      stop_pend_q <= stop_pend_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.data_valid = valid_q;
  assign bus.data_out   = data_q;
  assign bus.sof        = sof_q;
  assign bus.eof        = eof_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign burst_cnt      = burst_cnt_q;

endmodule

// File: tb/tb_data_gen_burst.sv
// Bench for data_gen_burst: three parameterisations share stimulus; each scenario
// resets them, then checks one instance against a word-index reference model.
module tb_data_gen_burst;

  logic       clk_50m = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       data_ready = 1'b0;
  logic [1:0] mode = 2'd0;

  always #5 clk_50m = ~clk_50m;

  data_gen_burst_if #(.DATA_W(8)) bus_a ();
  data_gen_burst_if #(.DATA_W(8)) bus_b ();
  data_gen_burst_if #(.DATA_W(8)) bus_c ();

  assign bus_a.data_ready = data_ready;
  assign bus_b.data_ready = data_ready;
  assign bus_c.data_ready = data_ready;

  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;

  data_gen_burst #(.DATA_W(8), .NUM_MAX(200), .BURST_LEN(16), .GAP_LEN(4), .NUM_BURSTS(0),
                   .LFSR_SEED(8'h01), .LFSR_TAPS(8'hB8)) dut_a (
    .clk_50m(clk_50m), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .bus(bus_a), .busy(busy_a), .done(done_a), .burst_cnt(cnt_a));

  data_gen_burst #(.DATA_W(8), .NUM_MAX(200), .BURST_LEN(16), .GAP_LEN(4), .NUM_BURSTS(2),
                   .LFSR_SEED(8'h01), .LFSR_TAPS(8'hB8)) dut_b (
    .clk_50m(clk_50m), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .bus(bus_b), .busy(busy_b), .done(done_b), .burst_cnt(cnt_b));

  data_gen_burst #(.DATA_W(8), .NUM_MAX(200), .BURST_LEN(1), .GAP_LEN(0), .NUM_BURSTS(0),
                   .LFSR_SEED(8'h01), .LFSR_TAPS(8'hB8)) dut_c (
    .clk_50m(clk_50m), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .bus(bus_c), .busy(busy_c), .done(done_c), .burst_cnt(cnt_c));

  typedef struct packed {
    logic        valid;
    logic        sof;
    logic        eof;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
    logic [7:0]  data;
  } obs_t;

  int   sel = 0;
  obs_t obs;
  int   checks = 0;
  int   errors = 0;

  always_comb begin
    obs = '0;
    case (sel)
      0:       obs = {bus_a.data_valid, bus_a.sof, bus_a.eof, busy_a, done_a, cnt_a, bus_a.data_out};
      1:       obs = {bus_b.data_valid, bus_b.sof, bus_b.eof, busy_b, done_b, cnt_b, bus_b.data_out};
      default: obs = {bus_c.data_valid, bus_c.sof, bus_c.eof, busy_c, done_c, cnt_c, bus_c.data_out};
    endcase
  end

  function automatic string fmt(input obs_t o);
    return $sformatf("v=%b sof=%b eof=%b busy=%b done=%b cnt=%0d data=%0d",
                     o.valid, o.sof, o.eof, o.busy, o.done, o.cnt, o.data);
  endfunction

  // The n-th word of a run, straight from each pattern's arithmetic definition.
  function automatic logic [7:0] exp_word(input logic [1:0] m, input int n);
    logic [7:0] s;
    s = 8'h00;
    case (m)
      2'd0: s = 8'(n % 200);
      2'd1: s = 8'(199 - (n % 200));
      2'd2: begin
        s = 8'h01;
        for (int i = 0; i < n; i++) s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
      end
      default: s = 8'(1 << (n % 8));
    endcase
    return s;
  endfunction

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; data_ready = 1'b0;
    @(negedge clk_50m);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e;
    e = '0;
    rst = 1'b1;
    @(negedge clk_50m);
    @(negedge clk_50m);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL reset dut%0d: got %s, expected %s", s, fmt(obs), fmt(e));
      end
    end
    rst = 1'b0;
    @(negedge clk_50m);
  endtask

  task automatic test_pattern(input logic [1:0] m, input bit rand_ready, input int ncycles, input string name);
    int   n, gap_left, bursts;
    obs_t e, care;
    n = 0; gap_left = 0; bursts = 0;
    sel = 0;
    apply_reset();
    mode = m; start = 1'b1;
    @(negedge clk_50m);
    start = 1'b0;
    for (int k = 0; k < ncycles; k++) begin
      e = '0; care = '1;
      e.busy = 1'b1;
      e.cnt  = 16'(bursts);
      if (gap_left > 0) begin
        care.data = '0;
        gap_left--;
      end else begin
        e.valid = 1'b1;
        e.data  = exp_word(m, n);
        e.sof   = (n % 16 == 0);
        e.eof   = (n % 16 == 15);
      end
      checks++;
      if ((obs & care) !== (e & care)) begin
        errors++;
        $display("[TB] FAIL %s k=%0d: got %s, expected %s", name, k, fmt(obs), fmt(e));
      end
      data_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (e.valid && data_ready) begin
        if (n % 16 == 15) begin
          bursts++;
          gap_left = 4;
        end
        n++;
      end
      @(negedge clk_50m);
    end
  endtask

  task automatic test_burst_limit();
    int   n;
    obs_t e, care;
    sel = 1;
    apply_reset();
    mode = 2'd1; start = 1'b1; data_ready = 1'b1;
    @(negedge clk_50m);
    start = 1'b0;
    for (int k = 0; k < 42; k++) begin
      e = '0; care = '1;
      n = (k < 16) ? k : k - 4;
      e.busy = (k < 36);
      e.cnt  = (k < 16) ? 16'd0 : (k < 36) ? 16'd1 : 16'd2;
      e.done = (k == 36);
      if (k < 16 || (k >= 20 && k < 36)) begin
        e.valid = 1'b1;
        e.data  = exp_word(2'd1, n);
        e.sof   = (n % 16 == 0);
        e.eof   = (n % 16 == 15);
      end else begin
        care.data = '0;
      end
      checks++;
      if ((obs & care) !== (e & care)) begin
        errors++;
        $display("[TB] FAIL burst_limit k=%0d: got %s, expected %s", k, fmt(obs), fmt(e));
      end
      @(negedge clk_50m);
    end
  endtask

  task automatic test_stop(input int stop_k);
    int   end_k;
    obs_t e, care;
    sel = 0;
    apply_reset();
    mode = 2'd0; start = 1'b1; data_ready = 1'b1;
    @(negedge clk_50m);
    start = 1'b0;
    end_k = (stop_k < 16) ? 16 : 20;
    for (int k = 0; k < 25; k++) begin
      e = '0; care = '1;
      e.busy = (k < end_k);
      e.done = (k == end_k);
      e.cnt  = (k >= 16) ? 16'd1 : 16'd0;
      if (k < 16) begin
        e.valid = 1'b1;
        e.data  = 8'(k);
        e.sof   = (k == 0);
        e.eof   = (k == 15);
      end else begin
        care.data = '0;
      end
      checks++;
      if ((obs & care) !== (e & care)) begin
        errors++;
        $display("[TB] FAIL stop@%0d k=%0d: got %s, expected %s", stop_k, k, fmt(obs), fmt(e));
      end
      stop  = (k == stop_k);
      start = (k == 8);
      mode  = (k == 8) ? 2'd3 : 2'd0;
      @(negedge clk_50m);
    end
    stop = 1'b0; start = 1'b0; mode = 2'd0;
  endtask

  task automatic test_start_stop_same();
    obs_t e, care;
    sel = 2;
    apply_reset();
    mode = 2'd0; start = 1'b1; stop = 1'b1; data_ready = 1'b1;
    @(negedge clk_50m);
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = '0; care = '1;
      if (k == 0) begin
        e.valid = 1'b1; e.sof = 1'b1; e.eof = 1'b1; e.busy = 1'b1; e.data = 8'd0;
      end else begin
        care.data = '0;
        e.cnt  = 16'd1;
        e.done = (k == 1);
      end
      checks++;
      if ((obs & care) !== (e & care)) begin
        errors++;
        $display("[TB] FAIL start_stop_same k=%0d: got %s, expected %s", k, fmt(obs), fmt(e));
      end
      @(negedge clk_50m);
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    sel = 2;
    apply_reset();
    mode = 2'd3; start = 1'b1; data_ready = 1'b1;
    @(negedge clk_50m);
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      e = '0;
      e.valid = 1'b1; e.sof = 1'b1; e.eof = 1'b1; e.busy = 1'b1;
      e.cnt   = 16'(k);
      e.data  = exp_word(2'd3, k);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL back_to_back k=%0d: got %s, expected %s", k, fmt(obs), fmt(e));
      end
      @(negedge clk_50m);
    end
  endtask

  task automatic test_reset_mid_burst();
    obs_t e;
    sel = 0;
    apply_reset();
    mode = 2'd2; start = 1'b1; data_ready = 1'b1;
    @(negedge clk_50m);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e = '0;
      e.valid = 1'b1; e.busy = 1'b1;
      e.sof   = (k == 0);
      e.data  = exp_word(2'd2, k);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL pre_reset k=%0d: got %s, expected %s", k, fmt(obs), fmt(e));
      end
      if (k < 7) @(negedge clk_50m);
    end
    data_ready = 1'b0; rst = 1'b1;
    @(negedge clk_50m);
    rst = 1'b0;
    e = '0;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("[TB] FAIL mid_reset: got %s, expected %s", fmt(obs), fmt(e));
    end
    mode = 2'd2; start = 1'b1;
    @(negedge clk_50m);
    start = 1'b0;
    e = '0;
    e.valid = 1'b1; e.sof = 1'b1; e.busy = 1'b1; e.data = 8'h01;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("[TB] FAIL restart: got %s, expected %s", fmt(obs), fmt(e));
    end
  endtask

  initial begin
    @(negedge clk_50m);
    test_reset();
    test_pattern(2'd0, 1'b0, 260, "inc");
    test_pattern(2'd2, 1'b1, 120, "lfsr");
    test_pattern(2'd3, 1'b1, 60, "walk1");
    test_burst_limit();
    test_stop(5);
    test_stop(17);
    test_start_stop_same();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_gen_burst.md
# data_gen_burst

Parametrised successor to the free-running counter source: generates test data in one of four selectable patterns, framed into bursts with programmable length and inter-burst gap. Uses a valid/ready handshake so it can feed the ping-pong buffer write side or any back-pressuring sink. Also provides start/stop control, burst framing flags and a burst counter for bench and on-board self-test use.

## Interface
- DATA_W, 8: data width in bits, 2..32
- NUM_MAX, 200: counter modulus for INC/DEC modes, 2..2^DATA_W
- BURST_LEN, 16: words per burst, >=1
- GAP_LEN, 4: idle cycles between bursts, 0 = back-to-back
- NUM_BURSTS, 0: bursts per run, 0 = unlimited until stop
- LFSR_SEED, 1: LFSR start value, must be nonzero
- LFSR_TAPS, 8'hB8: Galois feedback mask, DATA_W bits
- clk_50m  in  1  system clock; one clock domain
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle start pulse; honoured only in IDLE
- stop  in  1  one-cycle stop request; honoured at next burst boundary
- mode  in  2  0=INC, 1=DEC, 2=LFSR, 3=WALK1; sampled on accepted start
- data_ready  in  1  sink accepts data_out this cycle
- data_valid  out  1  data_out is valid
- data_out  out  DATA_W  pattern word
- sof  out  1  qualifies the first word of a burst, valid with data_valid
- eof  out  1  qualifies the last word of a burst, valid with data_valid
- busy  out  1  high in RUN or GAP
- done  out  1  one-cycle pulse on return to IDLE, except after reset
- burst_cnt  out  16  completed bursts since last accepted start, saturates at 16'hFFFF

## Operation
- FSM states: IDLE, RUN, GAP. All outputs are registered.
- IDLE -> RUN on start. On that edge:
  - latch mode
  - load the seed: INC 0, DEC NUM_MAX-1, LFSR LFSR_SEED, WALK1 1
  - clear the word counter, burst_cnt and stop_pend
- RUN:
  - data_valid=1; a transfer occurs when data_valid && data_ready.
  - On a transfer, advance the pattern and the word counter. Otherwise hold data_out, sof and eof stable. Valid must never drop without a transfer.
- Pattern advance:
  - INC: +1, wraps NUM_MAX-1 -> 0
  - DEC: -1, wraps 0 -> NUM_MAX-1
  - LFSR: shift right; if the shifted-out bit is 1, XOR with LFSR_TAPS
  - WALK1: rotate left by 1
- Continuity: the pattern continues across bursts within a run. It is reseeded only on start.
- Framing: sof=1 when word counter==0; eof=1 when word counter==BURST_LEN-1. BURST_LEN=1 gives sof and eof together.
- Transfer of the eof word:
  - increment burst_cnt and clear the word counter
  - if stop_pend, or NUM_BURSTS!=0 and the new burst_cnt==NUM_BURSTS: go to IDLE and pulse done
  - else if GAP_LEN==0: stay in RUN with the next word, sof=1
  - else: go to GAP
- GAP: data_valid=0 for exactly GAP_LEN cycles, then RUN. The pattern is held.
- stop:
  - Sets stop_pend in RUN or GAP.
  - stop during GAP: finish the gap, then return to IDLE without starting another burst. The done pulse is issued on the cycle the gap would have ended.
  - stop while in IDLE with no start is ignored.
- start while busy is ignored.
- start and stop in the same IDLE cycle: start is accepted and stop_pend is set, so exactly one burst is run.
- Reset: synchronous. From any state, including mid-burst with a transfer pending, the next edge forces IDLE. Reset values: data_valid=0, data_out=0, sof=0, eof=0, busy=0, done=0, burst_cnt=0, stop_pend=0.

## Timing
- start sampled at edge t: data_valid=1 with the seed word, sof=1 and busy=1 from edge t+1.
- With data_ready held high, throughput is one word per cycle. A burst occupies BURST_LEN cycles followed by GAP_LEN idle cycles.
- On a transfer at edge t, the next word appears at edge t+1. There is no combinational path from data_ready to outputs other than the registered advance.
- Transfer of the final eof word at edge t: at edge t+1, data_valid=0, busy=0 and done=1. done is low again at edge t+2.
- burst_cnt updates on the same edge as the eof transfer.

## Test plan
- INC, DATA_W=8, NUM_MAX=200, BURST_LEN=16, GAP_LEN=4, NUM_BURSTS=0, ready=1, start -> 0..15 with sof@0 and eof@15, then 4 invalid cycles, then 16..31. Across bursts, 198,199,0,1 wraps with no gap in the sequence.
- DEC, NUM_BURSTS=2, ready=1 -> 199 down to 168 over two bursts, burst_cnt reaches 2, one done pulse, busy=0, data_valid=0.
- LFSR, seed 1, taps 8'hB8, ready toggling 1010 -> values match the reference model in order with none skipped. data_out, sof and eof are stable while ready=0. WALK1 gives 1,2,4,...,128,1.
- stop pulse at word 5 of burst 0 -> burst completes through word 15, then done and IDLE. A start during the run has no effect.
- start and stop in the same cycle with BURST_LEN=1 -> a single word with sof=eof=1, then done.
- rst at word 7 with data_valid=1 and ready=0 -> next edge all outputs 0, state IDLE. A following start restarts from the seed with burst_cnt=0.
